if_id_skid_reg: RTL and testbench

Parametrised fetch-to-decode pipeline register for the 3-stage RISC-V core. It replaces a bare latch-everything stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush with NOP injection, and epoch tagging so fetches issued before a redirect are discarded. It also precomputes the compressed-instruction flag and fall-through PC for decode. It sits between the fetch unit (upstream) and decode/execute (downstream).

---
 rtl/if_id_skid_reg_if.sv | 32 +++
 rtl/if_id_skid_reg.sv | 99 +++++++++
 tb/tb_if_id_skid_reg.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle for if_id_skid_reg.
//   in_*   : upstream beat from fetch (valid/ready, instr, pc, epoch tag)
//   out_*  : downstream beat to decode (valid/ready, instr, pc, pc_next, compressed)
// slave  = the pipeline register side; master = the fetch/decode environment side.
interface if_id_skid_reg_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned EPOCH_W = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [ILEN-1:0]    in_instr;
  logic [XLEN-1:0]    in_pc;
  logic [EPOCH_W-1:0] in_epoch;

  logic               out_valid;
  logic               out_ready;
  logic [ILEN-1:0]    out_instr;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_pc_next;
  logic               out_compressed;

  modport slave (
    input  in_valid, in_instr, in_pc, in_epoch, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_next, out_compressed
  );

  modport master (
    output in_valid, in_instr, in_pc, in_epoch, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_next, out_compressed
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer, synchronous
// flush with NOP injection, and epoch tagging to discard wrong-path fetches.
// Ports:
//   clk        - clock, all state on posedge
//   reset      - synchronous, active-low
//   flush_i    - redirect: empties both entries and advances the epoch
//   bus        - handshake bundle (slave side), see if_id_skid_reg_if
//   epoch_o    - current epoch; fetch tags new requests with it
//   drop_cnt_o - saturating count of stale-epoch beats discarded
module if_id_skid_reg #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     ILEN    = 32,
  parameter logic [ILEN-1:0] NOP     = 32'h0000_0013,
  parameter int unsigned     EPOCH_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  if_id_skid_reg_if.slave     bus,
  output logic [EPOCH_W-1:0]  epoch_o,
  output logic [15:0]         drop_cnt_o
);

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            comp;
  } entry_t;

  entry_t             main_q, skid_q, in_entry;
  logic               main_valid, skid_valid;
  logic [EPOCH_W-1:0] epoch;
  logic [15:0]        drop_cnt;

  logic accept, fresh, stale, pop;

  // Decode-side helpers are computed once, when the beat is captured.
  always_comb begin
    in_entry         = '0;
    in_entry.instr   = bus.in_instr;
    in_entry.pc      = bus.in_pc;
    in_entry.comp    = (bus.in_instr[1:0] != 2'b11);
    in_entry.pc_next = bus.in_pc + (in_entry.comp ? XLEN'(2) : XLEN'(4));
  end

  // in_ready depends only on registered state and reset, never on out_ready.
  assign bus.in_ready = reset & ~skid_valid;
  assign accept       = bus.in_valid & bus.in_ready & ~flush_i;
  assign fresh        = accept & (bus.in_epoch == epoch);
  assign stale        = accept & (bus.in_epoch != epoch);
  assign pop          = main_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      epoch      <= '0;
      drop_cnt   <= '0;
    end else if (flush_i) begin
      // Payload of main is kept so out_pc/out_pc_next hold across the flush.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      epoch      <= epoch + EPOCH_W'(1);
    end else begin
      if (stale && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;

      if (pop) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= fresh;
          if (fresh) skid_q <= in_entry;
        end else begin
          main_valid <= fresh;
          if (fresh) main_q <= in_entry;
        end
      end else if (!main_valid) begin
        main_valid <= fresh;
        if (fresh) main_q <= in_entry;
      end else if (fresh) begin
        // Main full and stalled: absorb exactly one more beat.
        skid_valid <= 1'b1;
        skid_q     <= in_entry;
      end
    end
  end

  assign bus.out_valid      = main_valid;
  assign bus.out_instr      = main_valid ? main_q.instr : NOP;
  assign bus.out_pc         = main_q.pc;
  assign bus.out_pc_next    = main_q.pc_next;
  assign bus.out_compressed = main_q.comp;
  assign epoch_o            = epoch;
  assign drop_cnt_o         = drop_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned EPOCH_W = 2;
  localparam logic [31:0] NOPI    = 32'h0000_0013;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  epoch_o;
  logic [15:0] drop_cnt;

  if_id_skid_reg_if #(.XLEN(XLEN), .ILEN(ILEN), .EPOCH_W(EPOCH_W)) bus ();

  if_id_skid_reg #(.XLEN(XLEN), .ILEN(ILEN), .NOP(NOPI), .EPOCH_W(EPOCH_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .bus        (bus),
    .epoch_o    (epoch_o),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2 plus "last loaded beat" outputs.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  beat_t       q[$];
  int          m_epoch = 0;
  int          m_drop  = 0;
  logic [31:0] last_pc = '0, last_next = '0;
  logic        last_comp = 1'b0;

  task automatic model_edge();
    int occ;
    if (!reset) begin
      q.delete();
      m_epoch = 0; m_drop = 0;
      last_pc = '0; last_next = '0; last_comp = 1'b0;
    end else if (flush) begin
      q.delete();
      m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
    end else begin
      occ = q.size();
      if (occ > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && occ < 2) begin
        if (int'(bus.in_epoch) == m_epoch) q.push_back('{bus.in_instr, bus.in_pc});
        else if (m_drop < 65535) m_drop++;
      end
      if (q.size() > 0) begin
        last_pc   = q[0].pc;
        last_comp = (q[0].instr[1:0] != 2'b11);
        last_next = q[0].pc + (last_comp ? 32'd2 : 32'd4);
      end
    end
  endtask

  task automatic check_model();
    logic v;
    v = (q.size() > 0);
    chk("m_out_valid", bus.out_valid, v);
    chk("m_out_instr", bus.out_instr, v ? q[0].instr : NOPI);
    chk("m_out_pc", bus.out_pc, last_pc);
    chk("m_out_pc_next", bus.out_pc_next, last_next);
    chk("m_out_comp", bus.out_compressed, last_comp);
    chk("m_in_ready", bus.in_ready, reset && q.size() < 2);
    chk("m_epoch", epoch_o, m_epoch);
    chk("m_drop", drop_cnt, m_drop);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [1:0] ep, input logic ordy);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.in_epoch  = ep;
    bus.out_ready = ordy;
  endtask

  typedef struct {
    logic rst_n, fl, v;
    logic [31:0] instr, pc;
    logic [1:0] ep;
    logic ordy;
    logic e_valid;
    logic [31:0] e_instr, e_pc, e_next;
    logic e_comp, e_ready;
    logic [1:0] e_epoch;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1,0,1,32'h00000513,32'h000,0,1, 1,32'h00000513,32'h000,32'h004,0,1,0,0};
    tbl[1]  = '{1,0,1,32'h00400093,32'h004,0,1, 1,32'h00400093,32'h004,32'h008,0,1,0,0};
    tbl[2]  = '{1,0,1,32'h00800113,32'h008,0,1, 1,32'h00800113,32'h008,32'h00C,0,1,0,0};
    tbl[3]  = '{1,0,1,32'h00004501,32'h100,0,1, 1,32'h00004501,32'h100,32'h102,1,1,0,0};
    tbl[4]  = '{1,0,1,32'h00000513,32'h100,0,1, 1,32'h00000513,32'h100,32'h104,0,1,0,0};
    tbl[5]  = '{1,0,1,32'h00a00593,32'h200,0,0, 1,32'h00000513,32'h100,32'h104,0,0,0,0};
    tbl[6]  = '{1,0,1,32'h0000852e,32'h204,0,0, 1,32'h00000513,32'h100,32'h104,0,0,0,0};
    tbl[7]  = '{1,0,1,32'h0000852e,32'h204,0,1, 1,32'h00a00593,32'h200,32'h204,0,1,0,0};
    tbl[8]  = '{1,0,1,32'h0000852e,32'h204,0,1, 1,32'h0000852e,32'h204,32'h206,1,1,0,0};
    tbl[9]  = '{1,0,0,32'h00000000,32'h000,0,1, 0,32'h00000013,32'h204,32'h206,1,1,0,0};
    tbl[10] = '{1,0,1,32'h00c00613,32'h300,0,0, 1,32'h00c00613,32'h300,32'h304,0,1,0,0};
    tbl[11] = '{1,0,1,32'h00d00693,32'h304,0,0, 1,32'h00c00613,32'h300,32'h304,0,0,0,0};
    tbl[12] = '{1,1,1,32'h00e00713,32'h308,0,0, 0,32'h00000013,32'h300,32'h304,0,1,1,0};
    tbl[13] = '{1,0,1,32'h00f00793,32'h400,0,1, 0,32'h00000013,32'h300,32'h304,0,1,1,1};
    tbl[14] = '{1,0,1,32'h01000813,32'h404,1,1, 1,32'h01000813,32'h404,32'h408,0,1,1,1};
    tbl[15] = '{1,0,0,32'h00000000,32'h000,1,1, 0,32'h00000013,32'h404,32'h408,0,1,1,1};

    // Reset state
    drive(0, '0, '0, 0, 0);
    reset = 1'b0;
    step();
    step();
    chk("rst_out_instr", bus.out_instr, NOPI);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    reset = 1'b1;

    // Directed table: streaming, compressed, stall/skid, flush, stale drop
    for (int unsigned i = 0; i < 16; i++) begin
      reset = tbl[i].rst_n;
      flush = tbl[i].fl;
      drive(tbl[i].v, tbl[i].instr, tbl[i].pc, tbl[i].ep, tbl[i].ordy);
      step();
      chk($sformatf("t%0d_valid", i),   bus.out_valid,      tbl[i].e_valid);
      chk($sformatf("t%0d_instr", i),   bus.out_instr,      tbl[i].e_instr);
      chk($sformatf("t%0d_pc", i),      bus.out_pc,         tbl[i].e_pc);
      chk($sformatf("t%0d_pc_next", i), bus.out_pc_next,    tbl[i].e_next);
      chk($sformatf("t%0d_comp", i),    bus.out_compressed, tbl[i].e_comp);
      chk($sformatf("t%0d_in_ready", i), bus.in_ready,      tbl[i].e_ready);
      chk($sformatf("t%0d_epoch", i),   epoch_o,            tbl[i].e_epoch);
      chk($sformatf("t%0d_drop", i),    drop_cnt,           tbl[i].e_drop);
    end
    flush = 1'b0;

    // Reset mid-stall with skid full
    drive(1, 32'h00100093, 32'h500, 2'd1, 0);
    step();
    drive(1, 32'h00200113, 32'h504, 2'd1, 0);
    step();
    chk("stall_in_ready", bus.in_ready, 1'b0);
    drive(0, '0, '0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rst_mid_in_ready_low", bus.in_ready, 1'b0);
    step();
    chk("rst_mid_valid", bus.out_valid, 1'b0);
    chk("rst_mid_instr", bus.out_instr, NOPI);
    chk("rst_mid_pc", bus.out_pc, 32'h0);
    chk("rst_mid_drop", drop_cnt, 16'h0);
    chk("rst_mid_epoch", epoch_o, 2'd0);
    chk("rst_mid_in_ready_during", bus.in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready_after", bus.in_ready, 1'b1);

    // Epoch wrap: four flushes, each with a beat presented
    for (int unsigned k = 1; k <= 4; k++) begin
      flush = 1'b1;
      drive(1, 32'h00300193, 32'h600 + 32'(k * 4), 2'(k - 1), 1);
      step();
      chk($sformatf("wrap%0d_epoch", k), epoch_o, 2'(k % 4));
      chk($sformatf("wrap%0d_valid", k), bus.out_valid, 1'b0);
    end
    flush = 1'b0;
    drive(1, 32'h00400213, 32'h700, 2'd0, 1);
    step();
    chk("wrap_accept_valid", bus.out_valid, 1'b1);
    chk("wrap_accept_pc", bus.out_pc, 32'h700);
    chk("wrap_drop", drop_cnt, 16'h0);

    // Randomized traffic against the model
    for (int unsigned n = 0; n < 3000; n++) begin
      logic [1:0] ep;
      reset = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ep = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'(m_epoch);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, ep, ($urandom_range(0, 3) != 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
